// File: rtl/lms_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lms_pkg
// Description : Shared types and sizes for the adaptive ANC datapath
//               (sequencer, FIR and LMS blocks).
// Revision    : 1.0 - initial release
// ============================================================================
package lms_pkg;

    localparam int ARRAY_SIZE = 64;                  // taps / sample-buffer depth
    localparam int ADDR_W     = $clog2(ARRAY_SIZE);  // 6
    localparam int DATA_W     = 16;                  // signed sample width

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        START_FIR = 3'd2,
        WAIT_FIR  = 3'd3,
        START_LMS = 3'd4,
        WAIT_LMS  = 3'd5
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : seq_watchdog
// Description : Wait-state timeout counter. Cleared on entry to a wait,
//               counts every enabled cycle, flags expiry on the LIMIT-th
//               enabled cycle so the owner can abort on that same cycle.
// Ports       : clk_i     - clock
//               rst_ni    - asynchronous active-low reset
//               clear_i   - zero the counter
//               en_i      - count this cycle (owner is waiting)
//               expired_o - this is the LIMIT-th waiting cycle
// Revision    : 1.0 - initial release
// ============================================================================
module seq_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int              CNT_W   = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturate rather than wrap so a stray enable can never re-arm expiry.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of completed waiting cycles, so LIMIT-1
    // means the current cycle is the LIMIT-th one.
    assign expired_o = en_i && (count_q == CNT_W'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/lms_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lms_sequencer
// Description : Per-sample scheduler for the adaptive ANC path. Writes each
//               reference sample into the circular buffer, latches the error
//               sample, starts the FIR, then optionally fires one LMS update.
//               Owns the circular write pointer so FIR and LMS share the
//               same newest-sample index.
// Ports       : clk_in, rst_in (async active-low)
//               sample_valid_in/sample_in/error_in/adapt_en_in - new sample
//               clear_flags_in              - clears sticky flags
//               fir_done_in, lms_done_in    - completion from FIR / LMS
//               buf_we_out/buf_addr_out/buf_data_out - sample-buffer write
//               offset_out, error_out       - newest index, latched error
//               fir_start_out, lms_ready_out - 1-cycle start pulses
//               busy_out, overrun_out, timeout_out - status
// Revision    : 1.0 - initial release
// ============================================================================
module lms_sequencer
    import lms_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              sample_valid_in,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DATA_W-1:0] error_in,
    input  logic              adapt_en_in,
    input  logic              clear_flags_in,
    input  logic              fir_done_in,
    input  logic              lms_done_in,
    output logic              buf_we_out,
    output logic [ADDR_W-1:0] buf_addr_out,
    output logic [DATA_W-1:0] buf_data_out,
    output logic [ADDR_W-1:0] offset_out,
    output logic [DATA_W-1:0] error_out,
    output logic              fir_start_out,
    output logic              lms_ready_out,
    output logic              busy_out,
    output logic              overrun_out,
    output logic              timeout_out
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] offset_q;
    logic [DATA_W-1:0] sample_q;
    logic [DATA_W-1:0] error_q;
    logic              adapt_q;
    logic              overrun_q;
    logic              timeout_q;

    logic wd_clear;
    logic wd_en;
    logic wd_expired;
    logic timeout_set;

    seq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_in),
        .rst_ni    (rst_in),
        .clear_i   (wd_clear),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    // ------------------------------------------------------------------
    // Next-state / strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wd_clear    = 1'b0;
        wd_en       = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_valid_in) state_d = WRITE;
            end
            WRITE: begin
                state_d = START_FIR;
            end
            START_FIR: begin
                wd_clear = 1'b1;
                state_d  = WAIT_FIR;
            end
            WAIT_FIR: begin
                wd_en = 1'b1;
                // A done arriving on the expiry cycle still counts as success.
                if (fir_done_in) begin
                    state_d = adapt_q ? START_LMS : IDLE;
                end else if (wd_expired) begin
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end
            end
            START_LMS: begin
                wd_clear = 1'b1;
                state_d  = WAIT_LMS;
            end
            WAIT_LMS: begin
                wd_en = 1'b1;
                if (lms_done_in) begin
                    state_d = IDLE;
                end else if (wd_expired) begin
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            offset_q  <= '0;
            sample_q  <= '0;
            error_q   <= '0;
            adapt_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;

            // Only an accepted strobe (in IDLE) updates the latched sample set.
            if ((state_q == IDLE) && sample_valid_in) begin
                sample_q <= sample_in;
                error_q  <= error_in;
                adapt_q  <= adapt_en_in;
            end

            if (state_q == WRITE) begin
                offset_q <= wr_ptr_q;
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);  // natural wrap 63 -> 0
            end

            // Set has priority over clear on the sticky flags.
            if (sample_valid_in && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end else if (clear_flags_in) begin
                overrun_q <= 1'b0;
            end

            if (timeout_set) begin
                timeout_q <= 1'b1;
            end else if (clear_flags_in) begin
                timeout_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state, so reset forces them low)
    // ------------------------------------------------------------------
    assign buf_we_out    = (state_q == WRITE);
    assign buf_addr_out  = (state_q == WRITE) ? wr_ptr_q : '0;
    assign buf_data_out  = (state_q == WRITE) ? sample_q : '0;
    assign offset_out    = offset_q;
    assign error_out     = error_q;
    assign fir_start_out = (state_q == START_FIR);
    assign lms_ready_out = (state_q == START_LMS);
    assign busy_out      = (state_q != IDLE);
    assign overrun_out   = overrun_q;
    assign timeout_out   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_lms_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lms_sequencer
// Description : Directed self-checking bench for lms_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lms_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        sample_valid_in = 1'b0;
    logic [15:0] sample_in = '0;
    logic [15:0] error_in = '0;
    logic        adapt_en_in = 1'b0;
    logic        clear_flags_in = 1'b0;
    logic        fir_done_in = 1'b0;
    logic        lms_done_in = 1'b0;
    logic        buf_we_out;
    logic [5:0]  buf_addr_out;
    logic [15:0] buf_data_out;
    logic [5:0]  offset_out;
    logic [15:0] error_out;
    logic        fir_start_out;
    logic        lms_ready_out;
    logic        busy_out;
    logic        overrun_out;
    logic        timeout_out;

    int n_checks = 0;
    int n_fail   = 0;
    int fs_cnt   = 0;
    int lr_cnt   = 0;
    int we_cnt   = 0;

    lms_sequencer dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_valid_in (sample_valid_in),
        .sample_in       (sample_in),
        .error_in        (error_in),
        .adapt_en_in     (adapt_en_in),
        .clear_flags_in  (clear_flags_in),
        .fir_done_in     (fir_done_in),
        .lms_done_in     (lms_done_in),
        .buf_we_out      (buf_we_out),
        .buf_addr_out    (buf_addr_out),
        .buf_data_out    (buf_data_out),
        .offset_out      (offset_out),
        .error_out       (error_out),
        .fir_start_out   (fir_start_out),
        .lms_ready_out   (lms_ready_out),
        .busy_out        (busy_out),
        .overrun_out     (overrun_out),
        .timeout_out     (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk_in) begin
        if (fir_start_out) fs_cnt = fs_cnt + 1;
        if (lms_ready_out) lr_cnt = lr_cnt + 1;
        if (buf_we_out)    we_cnt = we_cnt + 1;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One-cycle strobe; returns sampled in the WRITE cycle. adapt_en_in is
    // flipped afterwards to show it is only sampled at the strobe.
    task automatic strobe(input logic [15:0] s, input logic [15:0] e, input logic a);
        sample_valid_in = 1'b1;
        sample_in       = s;
        error_in        = e;
        adapt_en_in     = a;
        tick();
        sample_valid_in = 1'b0;
        adapt_en_in     = ~a;
    endtask

    // From the WRITE cycle run the sequence back to IDLE.
    task automatic finish_seq(input logic a);
        tick();               // START_FIR
        tick();               // WAIT_FIR
        fir_done_in = 1'b1;
        tick();
        fir_done_in = 1'b0;
        if (a) begin
            tick();           // WAIT_LMS
            lms_done_in = 1'b1;
            tick();
            lms_done_in = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        #1;
        n_checks++;
        if ({buf_we_out, buf_addr_out, buf_data_out, offset_out, error_out,
             fir_start_out, lms_ready_out, busy_out, overrun_out, timeout_out} !== '0) begin
            $display("FAIL reset_outputs: got busy=%b we=%b offset=%h err=%h expected all zero",
                     busy_out, buf_we_out, offset_out, error_out);
            n_fail++;
        end
        repeat (3) tick();
        rst_in = 1'b1;
        tick();
        n_checks++;
        if (busy_out !== 1'b0) begin
            $display("FAIL reset_idle: busy got %b expected 0", busy_out);
            n_fail++;
        end
    endtask

    task automatic test_basic();
        int fs0 = fs_cnt;
        int lr0 = lr_cnt;
        strobe(16'h1234, 16'hFFFB, 1'b1);
        n_checks++;
        if ({buf_we_out, buf_addr_out, buf_data_out} !== {1'b1, 6'd0, 16'h1234}) begin
            $display("FAIL basic_write: got we=%b addr=%0d data=%h expected we=1 addr=0 data=1234",
                     buf_we_out, buf_addr_out, buf_data_out);
            n_fail++;
        end
        tick();
        n_checks++;
        if (fir_start_out !== 1'b1) begin
            $display("FAIL basic_fir_start: got %b expected 1", fir_start_out);
            n_fail++;
        end
        tick();
        n_checks++;
        if ({offset_out, error_out} !== {6'd0, 16'hFFFB}) begin
            $display("FAIL basic_offset_err: got offset=%0d err=%h expected offset=0 err=fffb",
                     offset_out, error_out);
            n_fail++;
        end
        repeat (9) tick();
        fir_done_in = 1'b1;
        tick();
        fir_done_in = 1'b0;
        n_checks++;
        if (lms_ready_out !== 1'b1) begin
            $display("FAIL basic_lms_ready: got %b expected 1", lms_ready_out);
            n_fail++;
        end
        tick();
        lms_done_in = 1'b1;
        tick();
        lms_done_in = 1'b0;
        n_checks++;
        if (busy_out !== 1'b0) begin
            $display("FAIL basic_idle: busy got %b expected 0", busy_out);
            n_fail++;
        end
        tick();
        n_checks++;
        if ((fs_cnt - fs0 != 1) || (lr_cnt - lr0 != 1)) begin
            $display("FAIL basic_pulses: got fir_start=%0d lms_ready=%0d expected 1 and 1",
                     fs_cnt - fs0, lr_cnt - lr0);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) begin
            strobe(16'(i * 3 + 7), 16'(i), 1'b0);
            n_checks++;
            if ({buf_we_out, buf_addr_out, buf_data_out} !== {1'b1, 6'(i), 16'(i * 3 + 7)}) begin
                $display("FAIL wrap_write_%0d: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                         i, buf_we_out, buf_addr_out, buf_data_out, i, 16'(i * 3 + 7));
                n_fail++;
            end
            finish_seq(1'b0);
        end
        strobe(16'hBEEF, 16'h0000, 1'b0);
        n_checks++;
        if ({buf_addr_out, buf_data_out} !== {6'd0, 16'hBEEF}) begin
            $display("FAIL wrap_65th_addr: got addr=%0d data=%h expected addr=0 data=beef",
                     buf_addr_out, buf_data_out);
            n_fail++;
        end
        tick();
        n_checks++;
        if (offset_out !== 6'd0) begin
            $display("FAIL wrap_65th_offset: got %0d expected 0", offset_out);
            n_fail++;
        end
        tick();
        fir_done_in = 1'b1;
        tick();
        fir_done_in = 1'b0;
    endtask

    task automatic test_no_adapt();
        int lr0 = lr_cnt;
        strobe(16'h0101, 16'h0002, 1'b0);
        n_checks++;
        if (buf_addr_out !== 6'd1) begin
            $display("FAIL noadapt_addr: got %0d expected 1", buf_addr_out);
            n_fail++;
        end
        tick();
        tick();
        repeat (3) tick();
        fir_done_in = 1'b1;
        tick();
        fir_done_in = 1'b0;
        n_checks++;
        if (busy_out !== 1'b0) begin
            $display("FAIL noadapt_busy_drop: got %b expected 0", busy_out);
            n_fail++;
        end
        repeat (3) tick();
        n_checks++;
        if (lr_cnt != lr0) begin
            $display("FAIL noadapt_lms_ready: got %0d pulses expected 0", lr_cnt - lr0);
            n_fail++;
        end
    endtask

    task automatic test_overrun();
        int we0;
        strobe(16'h0AAA, 16'h0001, 1'b0);
        n_checks++;
        if (buf_addr_out !== 6'd2) begin
            $display("FAIL ovr_first_addr: got %0d expected 2", buf_addr_out);
            n_fail++;
        end
        tick();
        tick();
        we0 = we_cnt;
        sample_valid_in = 1'b1;
        sample_in       = 16'h0BBB;
        tick();
        sample_valid_in = 1'b0;
        n_checks++;
        if ({overrun_out, busy_out} !== 2'b11) begin
            $display("FAIL ovr_flag: got overrun=%b busy=%b expected 1 1", overrun_out, busy_out);
            n_fail++;
        end
        repeat (2) tick();
        fir_done_in = 1'b1;
        tick();
        fir_done_in = 1'b0;
        n_checks++;
        if ((busy_out !== 1'b0) || (we_cnt != we0)) begin
            $display("FAIL ovr_dropped: got busy=%b extra_writes=%0d expected 0 0", busy_out, we_cnt - we0);
            n_fail++;
        end
        clear_flags_in = 1'b1;
        tick();
        clear_flags_in = 1'b0;
        n_checks++;
        if (overrun_out !== 1'b0) begin
            $display("FAIL ovr_clear: got %b expected 0", overrun_out);
            n_fail++;
        end
        strobe(16'h0CCC, 16'h0002, 1'b0);
        n_checks++;
        if ({buf_addr_out, buf_data_out} !== {6'd3, 16'h0CCC}) begin
            $display("FAIL ovr_ptr_once: got addr=%0d data=%h expected addr=3 data=0ccc",
                     buf_addr_out, buf_data_out);
            n_fail++;
        end
        tick();
        tick();
        // Set and clear in the same cycle: set wins.
        sample_valid_in = 1'b1;
        clear_flags_in  = 1'b1;
        tick();
        sample_valid_in = 1'b0;
        clear_flags_in  = 1'b0;
        n_checks++;
        if (overrun_out !== 1'b1) begin
            $display("FAIL ovr_set_wins: got %b expected 1", overrun_out);
            n_fail++;
        end
        clear_flags_in = 1'b1;
        tick();
        clear_flags_in = 1'b0;
        // Strobe on the done cycle is an overrun and starts nothing.
        we0 = we_cnt;
        fir_done_in     = 1'b1;
        sample_valid_in = 1'b1;
        tick();
        fir_done_in     = 1'b0;
        sample_valid_in = 1'b0;
        n_checks++;
        if ({overrun_out, busy_out} !== 2'b10) begin
            $display("FAIL ovr_done_cycle: got overrun=%b busy=%b expected 1 0", overrun_out, busy_out);
            n_fail++;
        end
        tick();
        n_checks++;
        if ((busy_out !== 1'b0) || (we_cnt != we0)) begin
            $display("FAIL ovr_done_cycle_nowrite: got busy=%b writes=%0d expected 0 0", busy_out, we_cnt - we0);
            n_fail++;
        end
        clear_flags_in = 1'b1;
        tick();
        clear_flags_in = 1'b0;
    endtask

    task automatic test_timeout();
        int lr0 = lr_cnt;
        strobe(16'h5555, 16'h0003, 1'b1);
        n_checks++;
        if (buf_addr_out !== 6'd4) begin
            $display("FAIL to_addr: got %0d expected 4", buf_addr_out);
            n_fail++;
        end
        tick();
        tick();               // first WAIT_FIR cycle
        repeat (254) tick();  // 255th WAIT_FIR cycle
        n_checks++;
        if ({busy_out, timeout_out} !== 2'b10) begin
            $display("FAIL to_early: got busy=%b timeout=%b expected 1 0", busy_out, timeout_out);
            n_fail++;
        end
        tick();
        n_checks++;
        if ({busy_out, timeout_out} !== 2'b01) begin
            $display("FAIL to_fire: got busy=%b timeout=%b expected 0 1", busy_out, timeout_out);
            n_fail++;
        end
        strobe(16'h6666, 16'h0004, 1'b0);
        n_checks++;
        if ({buf_we_out, buf_addr_out, buf_data_out} !== {1'b1, 6'd5, 16'h6666}) begin
            $display("FAIL to_next_seq: got we=%b addr=%0d data=%h expected we=1 addr=5 data=6666",
                     buf_we_out, buf_addr_out, buf_data_out);
            n_fail++;
        end
        finish_seq(1'b0);
        n_checks++;
        if ((lr_cnt != lr0) || (timeout_out !== 1'b1)) begin
            $display("FAIL to_sticky: got lms_ready=%0d timeout=%b expected 0 1", lr_cnt - lr0, timeout_out);
            n_fail++;
        end
        clear_flags_in = 1'b1;
        tick();
        clear_flags_in = 1'b0;
        n_checks++;
        if (timeout_out !== 1'b0) begin
            $display("FAIL to_clear: got %b expected 0", timeout_out);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        strobe(16'h7777, 16'h8000, 1'b1);
        n_checks++;
        if (buf_addr_out !== 6'd6) begin
            $display("FAIL rstmid_addr: got %0d expected 6", buf_addr_out);
            n_fail++;
        end
        tick();
        tick();
        fir_done_in = 1'b1;
        tick();
        fir_done_in = 1'b0;
        tick();               // WAIT_LMS
        n_checks++;
        if ({busy_out, offset_out, error_out} !== {1'b1, 6'd6, 16'h8000}) begin
            $display("FAIL rstmid_pre: got busy=%b offset=%0d err=%h expected 1 6 8000",
                     busy_out, offset_out, error_out);
            n_fail++;
        end
        #2;
        rst_in = 1'b0;
        #1;
        n_checks++;
        if ({buf_we_out, buf_addr_out, buf_data_out, offset_out, error_out,
             fir_start_out, lms_ready_out, busy_out, overrun_out, timeout_out} !== '0) begin
            $display("FAIL rstmid_async: got busy=%b offset=%0d err=%h expected all zero",
                     busy_out, offset_out, error_out);
            n_fail++;
        end
        tick();
        tick();
        rst_in = 1'b1;
        tick();
        strobe(16'h4321, 16'h0005, 1'b0);
        n_checks++;
        if ({buf_we_out, buf_addr_out, buf_data_out} !== {1'b1, 6'd0, 16'h4321}) begin
            $display("FAIL rstmid_first_write: got we=%b addr=%0d data=%h expected we=1 addr=0 data=4321",
                     buf_we_out, buf_addr_out, buf_data_out);
            n_fail++;
        end
        finish_seq(1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_no_adapt();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
